// File: rtl/ring_pkg.sv
// ring_pkg: definitions shared by the ring counter, its testbench and the
// ring code monitor.
//   ring_state_e   : monitor state encoding (HUNT, TRAIN, LOCKED)
//   DIR_UP, DIR_DN : rotation direction constants
//                    (up = bit i moves to bit i+1)
package ring_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRAIN  = 2'd1,
        LOCKED = 2'd2
    } ring_state_e;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/ring_code_monitor_if.sv
// ring_code_monitor_if: sample/status bundle of the ring code monitor.
//   en, ring_in, clr_err  : driven by the master (sampling side)
//   idx, idx_valid, locked, dir, code_err, step_err, err_count
//                         : driven by the slave (the monitor)
interface ring_code_monitor_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    localparam int IW = $clog2(WIDTH);

    logic             en;
    logic [WIDTH-1:0] ring_in;
    logic             clr_err;
    logic [IW-1:0]    idx;
    logic             idx_valid;
    logic             locked;
    logic             dir;
    logic             code_err;
    logic             step_err;
    logic [CNT_W-1:0] err_count;

    modport master (
        output en, ring_in, clr_err,
        input  idx, idx_valid, locked, dir, code_err, step_err, err_count
    );

    modport slave (
        input  en, ring_in, clr_err,
        output idx, idx_valid, locked, dir, code_err, step_err, err_count
    );
endinterface

// File: rtl/onehot_enc.sv
// onehot_enc: purely combinational one-hot check and binary encode.
//   ring_in : code under test
//   ok      : exactly one bit of ring_in is set
//   enc     : position of the set bit (only meaningful when ok)
module onehot_enc #(
    parameter  int WIDTH = 4,
    localparam int IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] ring_in,
    output logic             ok,
    output logic [IW-1:0]    enc
);

    assign ok = $onehot(ring_in);

    always_comb begin
        enc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ring_in[i]) enc = IW'(i);
        end
    end

endmodule

// File: rtl/ring_code_monitor.sv
// ring_code_monitor: receive-side checker for a one-hot ring-counter code.
// Validates and decodes each sampled code, learns the rotation direction,
// tracks lock, and flags and counts stepping faults once locked.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of ring_code_monitor_if (en, ring_in, clr_err in;
//           idx, idx_valid, locked, dir, code_err, step_err, err_count out)
module ring_code_monitor
    import ring_pkg::*;
#(
    parameter  int WIDTH    = 4,
    parameter  int LOCK_CNT = 3,
    parameter  int ERR_MAX  = 2,
    parameter  int CNT_W    = 8,
    localparam int IW       = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    ring_code_monitor_if.slave bus
);

    localparam int RW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(ERR_MAX + 1);

    ring_state_e      state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             dir_q, dir_d;
    logic [RW-1:0]    run_q, run_d;
    logic [BW-1:0]    bad_q, bad_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             code_err_q, code_err_d;
    logic             step_err_q, step_err_d;
    logic             err_inc;
    logic             step_good;

    logic             ok;
    logic [IW-1:0]    enc;
    logic [IW-1:0]    idx_up, idx_dn, idx_exp;

    onehot_enc #(.WIDTH(WIDTH)) u_enc (
        .ring_in (bus.ring_in),
        .ok      (ok),
        .enc     (enc)
    );

    // Neighbours of the current index with wrap-around at both ends.
    assign idx_up  = (idx_q == IW'(WIDTH - 1)) ? '0 : idx_q + 1'b1;
    assign idx_dn  = (idx_q == '0) ? IW'(WIDTH - 1) : idx_q - 1'b1;
    assign idx_exp = (dir_q == DIR_DN) ? idx_dn : idx_up;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            idx_q      <= '0;
            dir_q      <= DIR_UP;
            run_q      <= '0;
            bad_q      <= '0;
            err_q      <= '0;
            code_err_q <= 1'b0;
            step_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            dir_q      <= dir_d;
            run_q      <= run_d;
            bad_q      <= bad_d;
            err_q      <= err_d;
            code_err_q <= code_err_d;
            step_err_q <= step_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dir_d      = dir_q;
        run_d      = run_q;
        bad_d      = bad_q;
        code_err_d = 1'b0;
        step_err_d = 1'b0;
        err_inc    = 1'b0;
        step_good  = 1'b0;

        if (bus.en) begin
            case (state_q)
                HUNT: begin
                    if (ok) begin
                        state_d = TRAIN;
                        idx_d   = enc;
                        run_d   = '0;
                    end
                end

                TRAIN: begin
                    if (!ok) begin
                        state_d = HUNT;
                        dir_d   = DIR_UP;
                        run_d   = '0;
                    end else begin
                        idx_d = enc;
                        // The first step after a restart picks the direction;
                        // later steps must follow it.
                        if (run_q == '0 && enc == idx_up) begin
                            dir_d     = DIR_UP;
                            step_good = 1'b1;
                        end else if (run_q == '0 && enc == idx_dn) begin
                            dir_d     = DIR_DN;
                            step_good = 1'b1;
                        end else if (run_q != '0 && enc == idx_exp) begin
                            step_good = 1'b1;
                        end

                        if (step_good) begin
                            run_d = run_q + 1'b1;
                            if (int'(run_q) + 1 >= LOCK_CNT) begin
                                state_d = LOCKED;
                                bad_d   = '0;
                            end
                        end else begin
                            run_d = '0;
                        end
                    end
                end

                LOCKED: begin
                    if (ok && enc == idx_exp) begin
                        idx_d = enc;
                        bad_d = '0;
                    end else begin
                        err_inc = 1'b1;
                        // An invalid code carries no position, so the index
                        // flywheels to where the ring should have been.
                        if (!ok) begin
                            code_err_d = 1'b1;
                            idx_d      = idx_exp;
                        end else begin
                            step_err_d = 1'b1;
                            idx_d      = enc;
                        end
                        if (int'(bad_q) + 1 >= ERR_MAX) begin
                            state_d = HUNT;
                            dir_d   = DIR_UP;
                            bad_d   = '0;
                            run_d   = '0;
                        end else begin
                            bad_d = bad_q + 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = HUNT;
                    dir_d   = DIR_UP;
                    run_d   = '0;
                    bad_d   = '0;
                end
            endcase
        end
    end

    // Clear takes priority over a coincident increment; the count sticks at
    // all-ones rather than wrapping.
    always_comb begin
        err_d = err_q;
        if (bus.clr_err) begin
            err_d = '0;
        end else if (err_inc && err_q != '1) begin
            err_d = err_q + 1'b1;
        end
    end

    assign bus.idx       = idx_q;
    assign bus.idx_valid = (state_q != HUNT);
    assign bus.locked    = (state_q == LOCKED);
    assign bus.dir       = dir_q;
    assign bus.code_err  = code_err_q;
    assign bus.step_err  = step_err_q;
    assign bus.err_count = err_q;

endmodule

// File: doc/ring_code_monitor.md
# ring_code_monitor

Receive-side checker for the one-hot ring-counter code that the ring counter drives onto its `count` bus. It samples the code, validates it as one-hot, and decodes it to a binary index. It learns the rotation direction and tracks lock with a small state machine. Stepping faults are flagged and counted. It sits on the consumer side of a ring counter as a phase decoder and health monitor.

## Interface
- `WIDTH`, 4: ring length in bits; legal range 3..32.
- `LOCK_CNT`, 3: number of consecutive correct steps needed to enter LOCKED.
- `ERR_MAX`, 2: number of consecutive bad samples in LOCKED that drops lock.
- `CNT_W`, 8: width of the error counter.
- `IW` (localparam): `$clog2(WIDTH)`.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  sample strobe; `ring_in` is consumed only on edges where `en`=1.
- `ring_in`  in  WIDTH  ring code under test.
- `clr_err`  in  1  synchronous clear of `err_count`.
- `idx`  out  IW  decoded or expected index.
- `idx_valid`  out  1  `idx` is meaningful; state is not HUNT.
- `locked`  out  1  state is LOCKED.
- `dir`  out  1  rotation direction; 0 = up (bit i to i+1), 1 = down.
- `code_err`  out  1  one-cycle pulse; sampled code was not one-hot.
- `step_err`  out  1  one-cycle pulse; code was one-hot but not the expected next index.
- `err_count`  out  CNT_W  saturating count of errors.

## Operation
- Combinational check of `ring_in`: `ok` = exactly one bit set; `enc` = position of the set bit.
- "Correct step" means `enc` == (`idx`+1) mod WIDTH when `dir`=0, or (`idx`−1) mod WIDTH when `dir`=1. A held code (same index) counts as a wrong step.
- HUNT:
  - `ok` → go to TRAIN; `idx`←`enc`; `run`←0.
  - not `ok` → stay in HUNT. No error flags in HUNT.
- TRAIN:
  - First step: `enc` = `idx`±1 sets `dir` (+1 gives 0, −1 gives 1) and sets `run`←1.
  - Later steps must be correct per `dir`; each correct step increments `run`. `idx`←`enc`.
  - When `run` reaches LOCK_CNT → go to LOCKED with `bad`←0.
  - `ok` but wrong step → stay in TRAIN with `idx`←`enc`, `run`←0.
  - not `ok` → go to HUNT.
  - No error flags in TRAIN.
- LOCKED:
  - Correct step → `idx`←`enc`, `bad`←0.
  - Not `ok` → pulse `code_err`. `idx` flywheels to the expected index.
  - `ok` but wrong step → pulse `step_err`; `idx`←`enc`.
  - On either error, `bad`+1 and `err_count`+1. When `bad` reaches ERR_MAX → go to HUNT, and `idx_valid`, `locked` and `dir` clear.
- `err_count` saturates at all-ones. If `clr_err` and an increment occur on the same edge, `clr_err` wins and the result is 0.
- When `en`=0, state, `idx` and the counters hold, and both error pulses are 0.

## Timing
- Every output is a register, so each result appears one edge after its sample (latency 1).
- Reset while `rst`=0, at any time including mid-lock: state HUNT, and all outputs, `run` and `bad` are 0.
- Lock timing with back-to-back `en`: first code on edge 1, then three correct steps, so `locked`=1 is visible after edge 4.
- `code_err` and `step_err` are never high together. Each is high for exactly one cycle per bad sample.
- `idx` wraps: WIDTH−1 goes to 0 when up; 0 goes to WIDTH−1 when down.

## Structure
- Shared package `ring_pkg` holds:
  - state encoding: HUNT=2'd0, TRAIN=2'd1, LOCKED=2'd2;
  - direction constants: DIR_UP=0, DIR_DN=1.
- The ring counter's testbench and this block both import `ring_pkg`.
- Sub-module `onehot_enc #(WIDTH)`: purely combinational; `ring_in` → `ok`, `enc`.
- Top level contains the FSM, the `run`/`bad` counters, the `idx` register and the `err_count` counter.

## Test plan
All scenarios use WIDTH=4, LOCK_CNT=3, ERR_MAX=2 and `en`=1 unless stated otherwise.
- **Up lock:** 0001, 0010, 0100, 1000, 0001 → `idx` 0,1,2,3,0; `dir`=0; `locked`=1 after the 4th sample; no errors.
- **Down lock with wrap:** 1000, 0100, 0010, 0001, 1000 → `dir`=1; `idx` 3,2,1,0,3; locked.
- **Single code error while locked (up, `idx`=1):** inject 0110 → `code_err` pulses once; `err_count`=1; `idx`=2 (flywheel); stays locked. A following 1000 is accepted cleanly and clears `bad`.
- **Consecutive wrong steps while locked at `idx`=2:** 0100, 0100 → two `step_err` pulses; `err_count`=2; `locked`=0 and `idx_valid`=0 after the second. A following 0001 re-enters TRAIN.
- **Enable gaps:** `en`=0 for 5 cycles between valid steps → outputs are unchanged and there are no pulses; locking still completes on the 4th enabled sample.
- **Counter and reset edges:** with CNT_W=2, four errors → `err_count` saturates at 3. `clr_err` coincident with an error → 0. Drop `rst` while locked → all outputs are 0 immediately, asynchronously.
